// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control FSM and the shared datapath.
// Signals:
//   op, funct3, funct7b5, zero : instruction fields and ALU flag into the FSM
//   pc_write, adr_src, mem_write, ir_write, result_src,
//   alu_src_a, alu_src_b, alu_control, imm_src, reg_write : datapath controls
//   retire, illegal : instruction status
// master = control FSM side, slave = datapath side.
interface mc_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
           retire, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
           retire, illegal
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (returns to FETCH)
//   bus   : mc_control_fsm_if.master (instruction fields in, controls out)
// Parameter SUPPORT_BNE: 1 accepts funct3=001 branches, 0 traps them.
module mc_control_fsm #(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, JAL, ALUWB, BRANCH, ILLEGAL
  } state_t;

  state_t     state, state_next;
  logic [1:0] alu_op;

  function automatic logic is_legal(input logic [6:0] o, input logic [2:0] f3,
                                    input logic f7b5);
    logic ok;
    ok = 1'b0;
    case (o)
      7'b0000011, 7'b0100011: ok = (f3 == 3'b010);
      7'b0110011: ok = (f3 inside {3'b000, 3'b100, 3'b110, 3'b111}) &&
                       !(f7b5 && (f3 != 3'b000));
      7'b0010011: ok = (f3 inside {3'b000, 3'b100, 3'b110, 3'b111});
      7'b1100011: ok = (f3 == 3'b000) || (SUPPORT_BNE && (f3 == 3'b001));
      7'b1101111: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct7b5 only selects sub for R-type (op[5]=1); addi with imm[10]=1 stays add.
  function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [2:0] f3,
                                            input logic op5, input logic f7b5);
    logic [2:0] code;
    code = 3'b000;
    case (aop)
      2'b01: code = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  code = (op5 && f7b5) ? 3'b001 : 3'b000;
          3'b111:  code = 3'b010;
          3'b110:  code = 3'b011;
          3'b100:  code = 3'b100;
          default: code = 3'b000;
        endcase
      end
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.reg_write  = 1'b0;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;
    alu_op         = 2'b00;
    case (state)
      FETCH: begin
        bus.ir_write   = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.pc_write   = 1'b1;
        state_next     = DECODE;
      end
      DECODE: begin
        // ALU-out captures old PC + imm here so BRANCH/JAL can use the target.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        if (!is_legal(bus.op, bus.funct3, bus.funct7b5)) begin
          state_next = ILLEGAL;
        end else begin
          case (bus.op)
            7'b0000011, 7'b0100011: state_next = MEMADR;
            7'b0110011:             state_next = EXECR;
            7'b0010011:             state_next = EXECI;
            7'b1100011:             state_next = BRANCH;
            7'b1101111:             state_next = JAL;
            default:                state_next = ILLEGAL;
          endcase
        end
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_next    = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.adr_src = 1'b1;
        state_next  = MEMWB;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        bus.retire     = 1'b1;
        state_next     = FETCH;
      end
      MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        bus.retire    = 1'b1;
        state_next    = FETCH;
      end
      EXECR: begin
        bus.alu_src_a = 2'b10;
        alu_op        = 2'b10;
        state_next    = ALUWB;
      end
      EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        alu_op        = 2'b10;
        state_next    = ALUWB;
      end
      JAL: begin
        // ALU computes old PC + 4 (link) while PC loads the target from ALU-out.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        state_next    = ALUWB;
      end
      ALUWB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 2'b10;
        alu_op        = 2'b01;
        bus.retire    = 1'b1;
        // funct3[0] inverts the sense: beq takes on zero, bne on not-zero.
        bus.pc_write  = bus.zero ^ bus.funct3[0];
        state_next    = FETCH;
      end
      ILLEGAL: begin
        bus.illegal = 1'b1;
      end
      default: state_next = FETCH;
    endcase
    bus.alu_control = alu_decode(alu_op, bus.funct3, bus.op[5], bus.funct7b5);
    // Enables are suppressed for the whole reset interval, not just after the edge.
    if (!rst_n) begin
      bus.pc_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.ir_write  = 1'b0;
      bus.reg_write = 1'b0;
      bus.retire    = 1'b0;
    end
  end

  always_comb begin
    case (bus.op)
      7'b0100011: bus.imm_src = 2'b01;
      7'b1100011: bus.imm_src = 2'b10;
      7'b1101111: bus.imm_src = 2'b11;
      default:    bus.imm_src = 2'b00;
    endcase
  end

endmodule
